// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master req/ack arbiter and sequencer for the shared 128x16 RAM.
// Each access runs IDLE -> ACC -> ACK; the RAM port is driven only during ACC.
// Optional build macro: MEM_ARB_FIXED_PRIO_EN (m0 always wins on contention).
// Default build uses bounded-burst round-robin limited by MAX_BURST.
module mem_arbiter #(
    parameter int unsigned AW        = 12,
    parameter int unsigned DW        = 16,
    parameter int unsigned DEPTH     = 128,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_err,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_err,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,
    output logic          owner
);

    localparam int unsigned BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BurstOne = BW'(1);

    typedef enum logic [1:0] {StIdle, StAcc, StAck} state_e;

    state_e        state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic [BW-1:0] burst_q, burst_d;
    logic [1:0]    ack_q, ack_d;
    logic [1:0]    err_q, err_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;

    logic          cur_we;
    logic [AW-1:0] cur_addr;
    logic [DW-1:0] cur_wdata;
    logic          in_range;
    logic          winner;

    // Route the current owner's request onto the shared path.
    always_comb begin
        cur_we    = owner_q ? m1_we    : m0_we;
        cur_addr  = owner_q ? m1_addr  : m0_addr;
        cur_wdata = owner_q ? m1_wdata : m0_wdata;
        in_range  = (32'(cur_addr) < DEPTH);
    end

    // Pick the master to grant in IDLE.
    always_comb begin
`ifdef MEM_ARB_FIXED_PRIO_EN
        winner = ~m0_req;
`else
        if (m0_req && m1_req) begin
            // burst_q == 0 means nothing granted since reset, so "other" (m0) wins.
            if ((burst_q != '0) && (32'(burst_q) < MAX_BURST)) begin
                winner = last_q;
            end else begin
                winner = ~last_q;
            end
        end else begin
            winner = m1_req;
        end
`endif
    end

    // Next-state, RAM port and response capture.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        burst_d   = burst_q;
        ack_d     = '0;
        err_d     = err_q;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (m0_req || m1_req) begin
                    owner_d = winner;
                    last_d  = winner;
`ifndef MEM_ARB_FIXED_PRIO_EN
                    if (winner == last_q) begin
                        if (32'(burst_q) < MAX_BURST) begin
                            burst_d = burst_q + BurstOne;
                        end
                    end else begin
                        burst_d = BurstOne;
                    end
`endif
                    state_d = StAcc;
                end
            end
            StAcc: begin
                mem_addr  = cur_addr;
                mem_wdata = cur_wdata;
                mem_we    = cur_we & in_range;
                ack_d[owner_q] = 1'b1;
                err_d[owner_q] = ~in_range;
                if (owner_q) begin
                    rdata1_d = in_range ? mem_rdata : '0;
                end else begin
                    rdata0_d = in_range ? mem_rdata : '0;
                end
                state_d = StAck;
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            burst_q  <= '0;
            ack_q    <= '0;
            err_q    <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            burst_q  <= burst_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign m0_ack   = ack_q[0];
    assign m1_ack   = ack_q[1];
    assign m0_err   = err_q[0];
    assign m1_err   = err_q[1];
    assign m0_rdata = rdata0_q;
    assign m1_rdata = rdata1_q;
    assign owner    = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: drivers push expected responses per master,
// a negedge monitor pops and compares on every ack. RAM is modelled here.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [11:0] m0_addr, m1_addr, mem_addr;
    logic [15:0] m0_wdata, m1_wdata, mem_wdata, mem_rdata;
    logic        m0_ack, m1_ack, m0_err, m1_err, mem_we, owner;
    logic [15:0] m0_rdata, m1_rdata;

    logic [15:0] ram [128];

    typedef struct packed {
        logic [15:0] rdata;
        logic        err;
        logic        chk_rd;
    } exp_t;

    exp_t exp_q0[$];
    exp_t exp_q1[$];
    int   order_q[$];

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    int we_cnt = 0;

    mem_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_ack    (m0_ack),
        .m0_rdata  (m0_rdata),
        .m0_err    (m0_err),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_ack    (m1_ack),
        .m1_rdata  (m1_rdata),
        .m1_err    (m1_err),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .owner     (owner)
    );

    always #5 clk = ~clk;

    // RAM model: combinational read, synchronous write; out-of-range reads return junk.
    assign mem_rdata = (mem_addr < 12'd128) ? ram[mem_addr[6:0]] : 16'hDEAD;
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr[6:0]] <= mem_wdata;
    end

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (mem_we) we_cnt <= we_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Monitor: every ack is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (m0_ack && m1_ack) begin
                total_cnt++;
                $display("FAIL dual_ack: both acks high, expected at most one");
            end
            for (int m = 0; m < 2; m++) begin
                if ((m == 0) ? m0_ack : m1_ack) begin
                    exp_t e;
                    if (((m == 0) ? exp_q0.size() : exp_q1.size()) == 0) begin
                        total_cnt++;
                        $display("FAIL unexpected_ack m%0d: ack seen, none expected", m);
                    end else begin
                        e = (m == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        if (e.chk_rd)
                            check($sformatf("rdata_m%0d", m), (m == 0) ? m0_rdata : m1_rdata,
                                  e.rdata);
                        check($sformatf("err_m%0d", m), (m == 0) ? m0_err : m1_err, e.err);
                    end
                    if (order_q.size() != 0) check("grant_order", m, order_q.pop_front());
                end
            end
        end
    end

    // Issue one access from master m (called at posedge+1), wait for ack, then release.
    task automatic access(input int m, input logic we, input logic [11:0] addr,
                          input logic [15:0] wd, input logic [15:0] erd, input logic eerr,
                          input logic chk_rd, output int lat);
        exp_t e;
        int   t0;
        logic got;
        e.rdata  = erd;
        e.err    = eerr;
        e.chk_rd = chk_rd;
        if (m == 0) begin
            exp_q0.push_back(e);
            m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wd;
        end else begin
            exp_q1.push_back(e);
            m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wd;
        end
        t0  = cyc;
        got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            got = (m == 0) ? m0_ack : m1_ack;
        end
        lat = cyc - t0;
        if (!got) begin
            total_cnt++;
            $display("FAIL ack_timeout_m%0d: no ack within 50 cycles, expected one", m);
            lat = -1;
        end
        @(posedge clk);
        #1;
        if (m == 0) begin
            m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        end else begin
            m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, lat0, lat1, w0;
        for (int i = 0; i < 128; i++) ram[i] = 16'h4000 + 16'(i);
        ram[5] = 16'h1234;
        rst_n = 1'b0;
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset state
        check("rst_acks", {m0_ack, m1_ack, m0_err, m1_err}, 0);
        check("rst_m0_rdata", m0_rdata, 0);
        check("rst_m1_rdata", m1_rdata, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_owner", owner, 0);

        // Single read: ack lands in the third cycle (IDLE, ACC, ACK)
        w0 = we_cnt;
        access(0, 1'b0, 12'h005, 16'h0, 16'h1234, 1'b0, 1'b1, lat);
        check("read_latency", lat, 2);
        check("read_no_write", we_cnt - w0, 0);

        // Write then readback from m1
        w0 = we_cnt;
        access(1, 1'b1, 12'h07F, 16'hBEEF, 16'h0, 1'b0, 1'b0, lat);
        access(1, 1'b0, 12'h07F, 16'h0, 16'hBEEF, 1'b0, 1'b1, lat);
        check("write_once", we_cnt - w0, 1);
        check("ram_7f", ram[7'h7F], 16'hBEEF);

        // Out of range: write suppressed, read returns 0
        w0 = we_cnt;
        access(0, 1'b1, 12'h080, 16'h5555, 16'h0, 1'b1, 1'b1, lat);
        access(0, 1'b0, 12'h0FF, 16'h0, 16'h0, 1'b1, 1'b1, lat);
        check("oor_no_write", we_cnt - w0, 0);
        check("oor_ram0", ram[0], 16'h4000);

        // Idle gap: m0 drops, m1 requests two cycles later
        access(0, 1'b0, 12'h006, 16'h0, 16'h4006, 1'b0, 1'b1, lat0);
        repeat (2) @(posedge clk);
        #1;
        access(1, 1'b0, 12'h011, 16'h0, 16'h4011, 1'b0, 1'b1, lat1);
        check("gap_m0_latency", lat0, 2);
        check("gap_m1_latency", lat1, 2);

        // Reset during ACC of an m1 write
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 12'h010; m1_wdata = 16'h7777;
        @(posedge clk); #2;
        check("pre_rst_in_acc", {owner, mem_we}, 2'b11);
        rst_n = 1'b0;
        #1;
        check("rst_mid_mem_we", mem_we, 0);
        check("rst_mid_mem_addr", mem_addr, 0);
        check("rst_mid_mem_wdata", mem_wdata, 0);
        check("rst_mid_owner", owner, 0);
        check("rst_mid_ack", {m0_ack, m1_ack}, 0);
        check("rst_mid_m0_rdata", m0_rdata, 0);
        check("rst_mid_m1_rdata", m1_rdata, 0);
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_ram10", ram[7'h10], 16'h4010);

        // Contention from simultaneous first requests after reset
`ifdef MEM_ARB_FIXED_PRIO_EN
        order_q = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
`else
        order_q = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 1};
`endif
        fork
            begin
                int l0;
                for (int i = 0; i < 5; i++)
                    access(0, 1'b0, 12'(32'h20 + i), 16'h0, 16'(32'h4020 + i), 1'b0, 1'b1, l0);
            end
            begin
                int l1;
                for (int j = 0; j < 5; j++)
                    access(1, 1'b0, 12'(32'h30 + j), 16'h0, 16'(32'h4030 + j), 1'b0, 1'b1, l1);
            end
        join

        repeat (5) @(negedge clk);
        check("exp_q0_drained", exp_q0.size(), 0);
        check("exp_q1_drained", exp_q1.size(), 0);
        check("order_drained", order_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
